// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the queue-fed UART transmitter
// Contents: FSM state encoding, UART frame bit levels and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // 50 MHz system clock / 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with clear and terminal-count tick
// Ports:
//   m_clock  in   system clock
//   p_reset  in   synchronous active-high reset
//   clr      in   restart the bit period on the next edge
//   tick     out  high during the last cycle of a bit period
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic m_clock,
    input  logic p_reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_baud_cnt: CLKS_PER_BIT must be 2 or more");
        end
    endgenerate

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        // The counter only wraps through the explicit terminal compare.
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/queue_uart_tx.sv
// rtl/queue_uart_tx.sv - pops bytes from a FWFT queue and sends them as 8N1 UART frames
// Ports:
//   m_clock  in   system clock
//   p_reset  in   synchronous active-high reset
//   q_data   in   queue head, valid while q_empty=0
//   q_empty  in   queue is empty
//   q_pop    out  one-cycle pop per transmitted byte (combinational)
//   enable   in   allow new frames to start
//   txd      out  registered serial line, idle high
//   busy     out  frame in progress
module queue_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic [DATA_W-1:0] q_data,
    input  logic              q_empty,
    output logic              q_pop,
    input  logic              enable,
    output logic              txd,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              baud_clr;
    logic              tick;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .clr     (baud_clr),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        q_pop     = (state_q == IDLE) && !q_empty && enable && !p_reset;

        case (state_q)
            IDLE: begin
                txd_d  = STOP_BIT;
                busy_d = 1'b0;
                if (q_pop) begin
                    shreg_d = q_data;
                    state_d = START;
                    busy_d  = 1'b1;
                    txd_d   = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    txd_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = STOP;
                        txd_d   = STOP_BIT;
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Next bit is the new LSB after the shift.
                        txd_d     = shreg_d[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Restart the bit period on every state change; hold it cleared while idle.
        baud_clr = (state_d != state_q) || (state_q == IDLE);
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q   <= IDLE;
            txd_q     <= STOP_BIT;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_queue_uart_tx.sv
// tb/tb_queue_uart_tx.sv - self-checking bench for queue_uart_tx with a FWFT queue in front
module tb_queue_uart_tx;

    localparam int CPB = 4;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b1;
    logic       enable  = 1'b1;
    logic [7:0] q_data;
    logic       q_empty;
    logic       q_pop;
    logic       txd;
    logic       busy;

    logic       push_req  = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q [$];
    int         pop_count = 0;
    int         cyc = 0;
    int         pop_cycles [$];

    bit         mon_active = 1'b0;
    int         mon_k = 0;
    logic [7:0] mon_byte = 8'h00;

    always #5 m_clock = ~m_clock;

    queue_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8)
    ) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .q_data  (q_data),
        .q_empty (q_empty),
        .q_pop   (q_pop),
        .enable  (enable),
        .txd     (txd),
        .busy    (busy)
    );

    // Queue in front of the DUT; it is not cleared by p_reset.
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_data  = mem[rd_ptr];

    always @(posedge m_clock) begin
        if (push_req) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 4'd1;
        end
        if (q_pop) begin
            rd_ptr <= rd_ptr + 4'd1;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act != req) begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // Pop recorder.
    always @(negedge m_clock) begin
        cyc++;
        if (q_pop) begin
            pop_count++;
            pop_cycles.push_back(cyc);
            chk("pop_while_empty", int'(q_empty), 0);
        end
    end

    // Frame decoder / scoreboard: frame cycle k=0 is the first low txd sample.
    always @(negedge m_clock) begin
        if (p_reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_k      = 0;
            end
        end else begin
            mon_k++;
        end
        if (mon_active && !p_reset) begin
            if (mon_k >= 4 && mon_k < 36 && (mon_k % 4) == 2) begin
                mon_byte[(mon_k - 4) / 4] = txd;
            end
            if (mon_k == 38) begin
                chk("frame_stop_bit", int'(txd), 1);
            end
            if (mon_k == 39) begin
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", int'(mon_byte), -1);
                end else begin
                    chk("frame_byte", int'(mon_byte), int'(exp_q.pop_front()));
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge m_clock);
        #2;
    endtask

    task automatic push(input logic [7:0] b, input bit expect_tx);
        push_req  = 1'b1;
        push_data = b;
        if (expect_tx) exp_q.push_back(b);
        tick();
        push_req = 1'b0;
    endtask

    task automatic wait_pop(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge m_clock);
            if (q_pop) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(name, 0, 1);
    endtask

    // Samples the 40 frame cycles following the pop cycle.
    task automatic capture(output logic [9:0] sym, output int incons,
                           output int busy_n, output int lows);
        sym    = '0;
        incons = 0;
        busy_n = 0;
        lows   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge m_clock);
            if ((k % 4) == 0) sym[k / 4] = txd;
            else if (txd !== sym[k / 4]) incons++;
            if (busy === 1'b1) busy_n++;
            if (txd === 1'b0) lows++;
        end
    endtask

    initial begin
        logic [9:0] sym;
        int incons, busy_n, lows, bad, base;

        // Reset then idle
        tick();
        tick();
        p_reset = 1'b0;
        @(negedge m_clock);
        chk("reset_txd", int'(txd), 1);
        chk("reset_busy", int'(busy), 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge m_clock);
            if (txd !== 1'b1 || q_pop !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single byte 0x07
        tick();
        base = pop_count;
        push(8'h07, 1'b1);
        wait_pop("single_pop_timeout");
        capture(sym, incons, busy_n, lows);
        chk("single_symbols", int'(sym), int'(10'b1000001110));
        chk("single_symbol_hold", incons, 0);
        chk("single_busy_cycles", busy_n, 40);
        @(negedge m_clock);
        chk("single_busy_after", int'(busy), 0);
        chk("single_pops", pop_count - base, 1);
        chk("single_queue_empty", int'(q_empty), 1);

        // Back-to-back 0x07, 0x02, 0x03
        tick();
        base = pop_count;
        pop_cycles.delete();
        push(8'h07, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        repeat (3 * 41 + 20) @(negedge m_clock);
        chk("b2b_pops", pop_count - base, 3);
        if (pop_cycles.size() == 3) begin
            chk("b2b_spacing_1", pop_cycles[1] - pop_cycles[0], 41);
            chk("b2b_spacing_2", pop_cycles[2] - pop_cycles[1], 41);
        end else begin
            chk("b2b_pop_log", pop_cycles.size(), 3);
        end

        // Enable gating
        tick();
        enable = 1'b0;
        push(8'h3C, 1'b1);
        push(8'h81, 1'b1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge m_clock);
            if (q_pop !== 1'b0 || txd !== 1'b1) bad++;
        end
        chk("gate_hold_idle", bad, 0);
        tick();
        base = pop_count;
        enable = 1'b1;
        wait_pop("gate_pop_timeout");
        repeat (10) tick();
        enable = 1'b0;
        repeat (45) @(negedge m_clock);
        chk("gate_pops", pop_count - base, 1);
        chk("gate_queue_kept", int'(q_empty), 0);
        chk("gate_txd_idle", int'(txd), 1);
        tick();
        enable = 1'b1;
        wait_pop("gate_resume_timeout");
        repeat (45) @(negedge m_clock);

        // Reset mid-frame during DATA bit 3 of 0xA5
        tick();
        push(8'hA5, 1'b0);
        wait_pop("rst_pop_timeout");
        push(8'h96, 1'b1);
        repeat (17) tick();
        base = pop_count;
        p_reset = 1'b1;
        tick();
        @(negedge m_clock);
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_no_pop", int'(q_pop), 0);
        tick();
        p_reset = 1'b0;
        chk("rst_pops_during", pop_count - base, 0);
        wait_pop("rst_next_timeout");
        repeat (45) @(negedge m_clock);

        // 0x55 then 0xFF
        tick();
        enable = 1'b0;
        push(8'h55, 1'b1);
        push(8'hFF, 1'b1);
        enable = 1'b1;
        wait_pop("p55_pop_timeout");
        capture(sym, incons, busy_n, lows);
        chk("p55_symbols", int'(sym), int'(10'b1010101010));
        chk("p55_symbol_hold", incons, 0);
        wait_pop("pff_pop_timeout");
        capture(sym, incons, busy_n, lows);
        chk("pff_symbols", int'(sym), int'(10'b1111111110));
        chk("pff_low_cycles", lows, 4);
        repeat (5) @(negedge m_clock);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
